sha_msg_sched: RTL and testbench
================================

# sha_msg_sched

Message-schedule generator for the SHA-256 compression pipeline. It accepts one 512-bit padded message block and emits the 64-entry schedule W_0..W_63, one word per handshake beat, together with the matching round constant K_t and round index. It is the producer for the K/W inputs of the round stages and sits between the block loader and the round chain in the bitcoin miner.

## Interface
- WORD_W, 32, schedule word width; only 32 is supported (sigma functions are SHA-256 specific).
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64. Values below 64 are for bench use only.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- block_in  in  512  padded message block; block_in[511:480] is M_0, block_in[31:0] is M_15.
- block_valid  in  1  block_in is valid.
- block_ready  out  1  block is accepted on block_valid & block_ready.
- w_data  out  32  W_t.
- k_data  out  32  K_t.
- w_idx  out  6  t.
- w_last  out  1  high when t == ROUNDS-1.
- w_valid  out  1  w_data, k_data, w_idx and w_last are valid.
- w_ready  in  1  beat is consumed on w_valid & w_ready.
- flush  in  1  synchronous abort.
- done  out  1  one-cycle pulse after the final beat is consumed.

## Operation
- State machine with two states.
  - IDLE: block_ready=1, w_valid=0. A load moves the FSM to RUN and sets win[i]=M_i and t=0.
  - RUN: block_ready=0, w_valid=1. On the beat with t==ROUNDS-1 the FSM returns to IDLE.
- Window: 16x32 shift register win[0..15], with win[i]=W_{t+i}. w_data = win[0].
- On each accepted beat:
  - Shift win down by one.
  - Write win[15] = s1(win[14]) + win[9] + s0(win[1]) + win[0], computed mod 2^32.
  - Increment t.
  - One rule covers every t; there is no special case for t<16.
- Sigma functions:
  - s0(x) = ror7 ^ ror18 ^ shr3.
  - s1(x) = ror17 ^ ror19 ^ shr10.
- While w_valid=1 and w_ready=0, all outputs stay stable.
- flush is synchronous and has priority over a beat or load in the same cycle. The next state is IDLE, t=0, and done does not pulse. The window contents are don't-care.
- A block_valid that arrives during RUN waits until the FSM is back in IDLE, so the earliest re-load is the cycle after the last beat.
- When reset_n is asserted, including mid-block, outputs are:
  - block_ready=0, w_valid=0, done=0, w_last=0.
  - w_data=0, k_data=0, w_idx=0.
  - FSM in IDLE, win cleared.
  - block_ready goes to 1 in the first clock after reset_n deasserts.

## Timing
- Load to first beat: the load edge puts the FSM in RUN, and w_valid=1 with W_0 presented in the following cycle.
- Throughput is one word per cycle while w_ready=1, giving ROUNDS cycles per block plus 1 IDLE cycle.
- done is registered: it is high during the cycle after the final beat, which is also the first IDLE cycle.
- Outputs are registered. The sigma/add path is a single combinational stage into win[15].

## Configuration
- SHA_SCHED_KROM_EN defined: a 64-entry K constant ROM indexed by t is instantiated, and k_data = K_t (K_0=0x428a2f98 ... K_63=0xc67178f2).
- SHA_SCHED_KROM_EN undefined: the ROM is omitted and k_data is tied to 0; the downstream round supplies its own constants. All other behaviour is identical.

## Structure
- sha.vh holds:
  - The W_SIZE/W_MAX macros.
  - The s0/s1 sigma macros, added beside the existing ep0/ep1/ch/maj.
  - The K constant list.
- Sub-module sha_k_rom: combinational 6-bit address to 32-bit constant. It is instantiated only under SHA_SCHED_KROM_EN.

## Test plan
- Load the padded "abc" block (M_0=0x61626380, M_1..M_14=0, M_15=0x00000018) with w_ready=1. Require:
  - W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - k_data=0x428a2f98 at t=0 and 0xc67178f2 at t=63 (with the macro defined).
  - done one cycle after t=63.
- Hold w_ready low for 5 cycles at t=20: w_data, w_idx and k_data stay constant, and the following beats match the golden model.
- Drive block_valid high continuously over two blocks: block_ready rises only in the IDLE cycle, giving exactly 65 cycles between the two W_0 beats.
- Assert reset_n low asynchronously at t=30, mid-clock: all outputs go to 0 immediately, and block_ready=1 on the first edge after release.
- Pulse flush at t=10 while w_ready=1: no done pulse, IDLE next cycle, and a new block restarts at t=0 with the correct W_0.
- Compile without SHA_SCHED_KROM_EN: k_data=0 for all beats, and the W sequence is identical to the first scenario.

Source files
------------

// File: rtl/sha_msg_sched_pkg.sv
// Shared types, SHA-256 round constants and sigma helpers for the message scheduler.
package sha_msg_sched_pkg;

    localparam int SCHED_W = 32;
    localparam int WIN_N   = 16;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_msg_sched_if.sv
// Block-in / schedule-out handshake bundle for sha_msg_sched.
interface sha_msg_sched_if;
    import sha_msg_sched_pkg::*;

    logic [511:0]         block_in;
    logic                 block_valid;
    logic                 block_ready;
    logic [SCHED_W-1:0]   w_data;
    logic [SCHED_W-1:0]   k_data;
    logic [5:0]           w_idx;
    logic                 w_last;
    logic                 w_valid;
    logic                 w_ready;
    logic                 flush;
    logic                 done;

    modport slave (
        input  block_in, block_valid, w_ready, flush,
        output block_ready, w_data, k_data, w_idx, w_last, w_valid, done
    );

    modport master (
        output block_in, block_valid, w_ready, flush,
        input  block_ready, w_data, k_data, w_idx, w_last, w_valid, done
    );
endinterface

// File: rtl/sha_msg_sched_k_rom.sv
// Combinational SHA-256 round-constant lookup, K_t by round index.
module sha_k_rom
    import sha_msg_sched_pkg::*;
(
    input  logic [5:0]  addr_i,
    output logic [31:0] k_o
);
    assign k_o = K_TAB[addr_i];
endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window emitting W_t/K_t per beat.
// Optional K ROM enabled by defining SHA_SCHED_KROM_EN.
module sha_msg_sched
    import sha_msg_sched_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    sha_msg_sched_if.slave sch
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_N];
    logic [WORD_W-1:0] win_d [WIN_N];
    logic [5:0]        t_q, t_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] w_new;
    logic              load, beat, last;

    // rdy_q is only ever set while IDLE, so it doubles as the IDLE qualifier
    assign load  = rdy_q & sch.block_valid;
    assign beat  = vld_q & sch.w_ready;
    assign last  = (t_q == 6'(ROUNDS - 1));
    assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        done_d  = 1'b0;
        if (sch.flush) begin
            state_d = S_IDLE;
            t_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: if (load) begin
                    state_d = S_RUN;
                    t_d     = '0;
                    for (int i = 0; i < WIN_N; i++)
                        win_d[i] = sch.block_in[511 - WORD_W*i -: WORD_W];
                end
                S_RUN: if (beat) begin
                    for (int i = 0; i < WIN_N - 1; i++)
                        win_d[i] = win_q[i+1];
                    win_d[WIN_N-1] = w_new;
                    t_d = t_q + 6'd1;
                    if (last) begin
                        state_d = S_IDLE;
                        t_d     = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        rdy_d = (state_d == S_IDLE);
        vld_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign sch.block_ready = rdy_q;
    assign sch.w_valid     = vld_q;
    assign sch.w_data      = win_q[0];
    assign sch.w_idx       = t_q;
    assign sch.w_last      = vld_q & last;
    assign sch.done        = done_q;

`ifdef SHA_SCHED_KROM_EN
    logic [31:0] k_rom;
    sha_k_rom u_krom (.addr_i(t_q), .k_o(k_rom));
    // gated so k_data reads zero outside RUN, including under reset
    assign sch.k_data = vld_q ? k_rom : '0;
`else
    assign sch.k_data = '0;
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: abc block, stall, back-to-back, reset, flush.
module tb_sha_msg_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nerr = 0;
    int   nchk = 0;
    int   cyc  = 0;
    logic [31:0]  gold [64];
    logic [511:0] blk_a, blk_b;
    logic [31:0]  hd, hk;
    logic [5:0]   hi;
    int c0, c1;

    sha_msg_sched_if bus();

    sha_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut (
        .clk(clk), .reset_n(rst_n), .sch(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic fill_gold(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) gold[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            gold[t] = (ror(gold[t-2], 17) ^ ror(gold[t-2], 19) ^ (gold[t-2] >> 10))
                    + gold[t-7]
                    + (ror(gold[t-15], 7) ^ ror(gold[t-15], 18) ^ (gold[t-15] >> 3))
                    + gold[t-16];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.block_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.block_ready), 32'd1);
    endtask

    task automatic k_chk(input int t);
`ifdef SHA_SCHED_KROM_EN
        if (t == 0)  chk("k@0",  bus.k_data, 32'h428a2f98);
        if (t == 1)  chk("k@1",  bus.k_data, 32'h71374491);
        if (t == 20) chk("k@20", bus.k_data, 32'h2de92c6f);
        if (t == 63) chk("k@63", bus.k_data, 32'hc67178f2);
`else
        chk($sformatf("k0@%0d", t), bus.k_data, 32'h0);
`endif
    endtask

    // check one beat at the current negedge, then advance a cycle
    task automatic beat(input int t);
        chk($sformatf("w_valid@%0d", t), 32'(bus.w_valid), 32'd1);
        chk($sformatf("w_data@%0d", t), bus.w_data, gold[t]);
        chk($sformatf("w_idx@%0d", t), 32'(bus.w_idx), 32'(t));
        chk($sformatf("w_last@%0d", t), 32'(bus.w_last), 32'(t == 63));
        chk($sformatf("rdy_run@%0d", t), 32'(bus.block_ready), 32'd0);
        k_chk(t);
        @(negedge clk);
    endtask

    task automatic finish_block();
        chk("done_hi", 32'(bus.done), 32'd1);
        chk("idle_valid", 32'(bus.w_valid), 32'd0);
        chk("idle_ready", 32'(bus.block_ready), 32'd1);
        @(negedge clk);
        chk("done_lo", 32'(bus.done), 32'd0);
    endtask

    task automatic load(input logic [511:0] blk);
        bus.block_in    = blk;
        bus.block_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        bus.block_valid = 1'b0;
    endtask

    initial begin
        blk_a = '0;
        blk_a[511:480] = 32'h61626380;
        blk_a[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++)
            blk_b[511 - 32*i -: 32] = 32'h01234567 + 32'(i) * 32'h11111111;
        bus.block_in = '0; bus.block_valid = 1'b0;
        bus.w_ready = 1'b1; bus.flush = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.block_ready), 32'd0);
        chk("rst_valid", 32'(bus.w_valid), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_wdata", bus.w_data, 32'd0);
        chk("rst_kdata", bus.k_data, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_ready_early", 32'(bus.block_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready", 32'(bus.block_ready), 32'd1);

        // abc block with hand-derived words
        fill_gold(blk_a);
        load(blk_a);
        for (int t = 0; t < 64; t++) begin
            if (t == 0)  chk("W0_hand",  bus.w_data, 32'h61626380);
            if (t == 15) chk("W15_hand", bus.w_data, 32'h00000018);
            if (t == 16) chk("W16_hand", bus.w_data, 32'h61626380);
            if (t == 17) chk("W17_hand", bus.w_data, 32'h000F0000);
            beat(t);
        end
        finish_block();

        // stall for 5 cycles at t=20
        load(blk_a);
        for (int t = 0; t < 20; t++) beat(t);
        bus.w_ready = 1'b0;
        hd = bus.w_data; hk = bus.k_data; hi = bus.w_idx;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.w_valid), 32'd1);
            chk("stall_data", bus.w_data, hd);
            chk("stall_k", bus.k_data, hk);
            chk("stall_idx", 32'(bus.w_idx), 32'(hi));
        end
        chk("stall_gold", hd, gold[20]);
        chk("stall_idx20", 32'(hi), 32'd20);
        bus.w_ready = 1'b1;
        for (int t = 20; t < 64; t++) beat(t);
        finish_block();

        // block_valid held across two blocks: 65 cycles between W_0 beats
        bus.block_in = blk_a; bus.block_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        c0 = cyc;
        bus.block_in = blk_b;
        for (int t = 0; t < 64; t++) beat(t);
        chk("b2b_idle_ready", 32'(bus.block_ready), 32'd1);
        chk("b2b_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        c1 = cyc;
        bus.block_valid = 1'b0;
        chk("b2b_gap", 32'(c1 - c0), 32'd65);
        fill_gold(blk_b);
        for (int t = 0; t < 64; t++) beat(t);
        finish_block();

        // asynchronous reset mid-block at t=30
        load(blk_b);
        for (int t = 0; t < 30; t++) beat(t);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.block_ready), 32'd0);
        chk("arst_valid", 32'(bus.w_valid), 32'd0);
        chk("arst_done",  32'(bus.done), 32'd0);
        chk("arst_last",  32'(bus.w_last), 32'd0);
        chk("arst_wdata", bus.w_data, 32'd0);
        chk("arst_kdata", bus.k_data, 32'd0);
        chk("arst_idx",   32'(bus.w_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 32'(bus.block_ready), 32'd1);

        // flush at t=10 with w_ready high
        load(blk_b);
        for (int t = 0; t < 10; t++) beat(t);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_valid", 32'(bus.w_valid), 32'd0);
        chk("flush_ready", 32'(bus.block_ready), 32'd1);
        chk("flush_done",  32'(bus.done), 32'd0);
        chk("flush_idx",   32'(bus.w_idx), 32'd0);
        @(negedge clk);
        chk("flush_done2", 32'(bus.done), 32'd0);
        fill_gold(blk_a);
        load(blk_a);
        for (int t = 0; t < 64; t++) beat(t);
        finish_block();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
